// File: rtl/cmos_i2c_pkg.sv
// rtl/cmos_i2c_pkg.sv - shared widths, state codes and wait helper for the cmos_i2c config path
package cmos_i2c_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 8;
   localparam int CNT_W  = 24;
   localparam int ST_W   = 3;

   localparam logic [ADDR_W-1:0] DELAY_ADDR_DEF = 16'hFFFF;

   localparam logic [ST_W-1:0] ST_PWRUP = 3'd0;
   localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
   localparam logic [ST_W-1:0] ST_ISSUE = 3'd2;
   localparam logic [ST_W-1:0] ST_DELAY = 3'd3;
   localparam logic [ST_W-1:0] ST_NEXT  = 3'd4;
   localparam logic [ST_W-1:0] ST_GAP   = 3'd5;
   localparam logic [ST_W-1:0] ST_DONE  = 3'd6;
   localparam logic [ST_W-1:0] ST_ERROR = 3'd7;

   // The counter is consulted down to zero, so an N-cycle wait loads N-1; N=0 still costs one cycle.
   function automatic logic [CNT_W-1:0] wait_len(input logic [CNT_W-1:0] cyc);
      return (cyc == '0) ? '0 : cyc - CNT_W'(1);
   endfunction

endpackage

// File: rtl/cfg_wait_counter.sv
// rtl/cfg_wait_counter.sv - loadable down-counter with zero flag shared by the sequencer wait states
module cfg_wait_counter
   import cmos_i2c_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cmos_i2c_cfg_sequencer.sv
// rtl/cmos_i2c_cfg_sequencer.sv - walks the sensor register LUT and issues one I2C write per entry
module cmos_i2c_cfg_sequencer
   import cmos_i2c_pkg::*;
#(
   parameter logic [19:0] PWRUP_CYC      = 20'd500000,
   parameter logic [15:0] GAP_CYC        = 16'd1000,
   parameter logic [15:0] DELAY_UNIT_CYC = 16'd50000,
   parameter logic [15:0] DELAY_ADDR     = DELAY_ADDR_DEF,
   parameter logic [3:0]  MAX_RETRY      = 4'd3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     restart,
   output logic [IDX_W-1:0]         LUT_INDEX,
   input  logic [ADDR_W+DATA_W-1:0] LUT_DATA,
   input  logic [IDX_W-1:0]         LUT_SIZE,
   output logic                     wr_req,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_done,
   input  logic                     wr_nack,
   output logic                     cfg_busy,
   output logic                     cfg_done,
   output logic                     cfg_err,
   output logic [IDX_W-1:0]         err_index
);

   logic [ST_W-1:0]   state;
   logic [3:0]        retry_cnt;
   logic              pwr_armed;
   logic              gap_to_issue;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_load_val;
   logic              cnt_zero;
   logic [ADDR_W-1:0] lut_addr;
   logic [DATA_W-1:0] lut_val;
   logic [CNT_W-1:0]  delay_cyc;
   logic              is_delay;
   logic              last_entry;
   logic              can_retry;

   assign lut_addr   = LUT_DATA[ADDR_W+DATA_W-1:DATA_W];
   assign lut_val    = LUT_DATA[DATA_W-1:0];
   assign delay_cyc  = CNT_W'(lut_val) * CNT_W'(DELAY_UNIT_CYC);
   assign is_delay   = (lut_addr == DELAY_ADDR);
   assign last_entry = (LUT_SIZE == '0) || (LUT_INDEX >= LUT_SIZE - IDX_W'(1));
   assign can_retry  = (retry_cnt < MAX_RETRY);

   // Counter is loaded on the edge that enters a wait state, so the wait state itself only watches zero.
   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state)
         ST_PWRUP: begin
            cnt_load     = !pwr_armed;
            cnt_load_val = wait_len(CNT_W'(PWRUP_CYC));
         end
         ST_FETCH: begin
            cnt_load     = is_delay;
            cnt_load_val = wait_len(delay_cyc);
         end
         ST_ISSUE: begin
            cnt_load     = wr_nack && can_retry;
            cnt_load_val = wait_len(CNT_W'(GAP_CYC));
         end
         ST_NEXT: begin
            cnt_load     = !last_entry;
            cnt_load_val = wait_len(CNT_W'(GAP_CYC));
         end
         ST_DONE, ST_ERROR: begin
            cnt_load     = restart;
            cnt_load_val = wait_len(CNT_W'(PWRUP_CYC));
         end
         default: ;
      endcase
   end

   cfg_wait_counter #(.W(CNT_W)) u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_PWRUP;
         retry_cnt    <= '0;
         pwr_armed    <= 1'b0;
         gap_to_issue <= 1'b0;
         LUT_INDEX    <= '0;
         wr_req       <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         cfg_busy     <= 1'b1;
         cfg_done     <= 1'b0;
         cfg_err      <= 1'b0;
         err_index    <= '0;
      end else begin
         case (state)
            ST_PWRUP: begin
               if (!pwr_armed) begin
                  pwr_armed <= 1'b1;
               end else if (cnt_zero) begin
                  if (LUT_SIZE != '0) begin
                     state <= ST_FETCH;
                  end else begin
                     state    <= ST_DONE;
                     cfg_done <= 1'b1;
                     cfg_busy <= 1'b0;
                  end
               end
            end
            ST_FETCH: begin
               if (is_delay) begin
                  state <= (delay_cyc == '0) ? ST_NEXT : ST_DELAY;
               end else begin
                  wr_addr <= lut_addr;
                  wr_data <= lut_val;
                  wr_req  <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // A simultaneous done+nack is a failed transaction.
               if (wr_nack) begin
                  wr_req <= 1'b0;
                  if (can_retry) begin
                     retry_cnt    <= retry_cnt + 4'd1;
                     gap_to_issue <= 1'b1;
                     state        <= ST_GAP;
                  end else begin
                     state     <= ST_ERROR;
                     cfg_err   <= 1'b1;
                     cfg_busy  <= 1'b0;
                     err_index <= LUT_INDEX;
                  end
               end else if (wr_done) begin
                  wr_req    <= 1'b0;
                  retry_cnt <= '0;
                  state     <= ST_NEXT;
               end
            end
            ST_DELAY: begin
               if (cnt_zero) state <= ST_NEXT;
            end
            ST_NEXT: begin
               if (last_entry) begin
                  state    <= ST_DONE;
                  cfg_done <= 1'b1;
                  cfg_busy <= 1'b0;
               end else begin
                  LUT_INDEX    <= LUT_INDEX + IDX_W'(1);
                  gap_to_issue <= 1'b0;
                  state        <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_zero) begin
                  if (gap_to_issue) begin
                     wr_req <= 1'b1;
                     state  <= ST_ISSUE;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (restart) begin
                  state     <= ST_PWRUP;
                  pwr_armed <= 1'b1;
                  retry_cnt <= '0;
                  LUT_INDEX <= '0;
                  cfg_busy  <= 1'b1;
                  cfg_done  <= 1'b0;
                  cfg_err   <= 1'b0;
                  err_index <= '0;
               end
            end
            default: state <= ST_PWRUP;
         endcase
      end
   end

endmodule

// File: tb/tb_cmos_i2c_cfg_sequencer.sv
// tb/tb_cmos_i2c_cfg_sequencer.sv - scoreboard bench for the LUT-driven I2C config sequencer
`timescale 1ns/1ps
module tb_cmos_i2c_cfg_sequencer;

   localparam int PWRUP   = 10;
   localparam int GAP     = 4;
   localparam int UNIT    = 100;
   localparam int MAXR    = 3;
   localparam int ACK_LAT = 8;
   localparam int K_SKIP  = 0;
   localparam int K_EXACT = 1;
   localparam int K_MIN   = 2;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          kind;
      int          idle;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        restart = 1'b0;
   logic [7:0]  lut_index;
   logic [23:0] lut_data;
   logic [7:0]  lut_size = 8'd16;
   logic        wr_req;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_done = 1'b0;
   logic        wr_nack = 1'b0;
   logic        cfg_busy, cfg_done, cfg_err;
   logic [7:0]  err_index;

   logic [23:0] lut [256];
   int          nack_plan [256];
   bit          both_plan [256];
   int          attempts [256];
   bit          stray_en = 1'b0;
   exp_t        sbq [$];
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   assign lut_data = lut[lut_index];

   cmos_i2c_cfg_sequencer #(
      .PWRUP_CYC      (20'd10),
      .GAP_CYC        (16'd4),
      .DELAY_UNIT_CYC (16'd100),
      .DELAY_ADDR     (16'hFFFF),
      .MAX_RETRY      (4'd3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart),
      .LUT_INDEX (lut_index),
      .LUT_DATA  (lut_data),
      .LUT_SIZE  (lut_size),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_done   (wr_done),
      .wr_nack   (wr_nack),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .err_index (err_index)
   );

   a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (wr_req && $past(wr_req)) |-> ($stable(wr_addr) && $stable(wr_data)))
      else $error("FAIL wr_stable_assert: addr/data moved while wr_req high");

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // I2C master stand-in: answers ACK_LAT cycles into each request, NACKing per plan.
   initial begin : master
      int lat;
      int idx;
      lat = 0;
      forever begin
         @(negedge clk);
         wr_done = 1'b0;
         wr_nack = 1'b0;
         if (!rst_n || !wr_req) begin
            lat = 0;
            if (rst_n && stray_en && $urandom_range(0, 7) == 0) begin
               if ($urandom_range(0, 1) == 1) wr_done = 1'b1;
               else wr_nack = 1'b1;
            end
         end else begin
            lat++;
            if (lat == ACK_LAT) begin
               idx = int'(lut_index);
               if (attempts[idx] < nack_plan[idx]) begin
                  wr_nack = 1'b1;
                  if (both_plan[idx]) wr_done = 1'b1;
               end else begin
                  wr_done = 1'b1;
               end
               attempts[idx]++;
               lat = 0;
            end
         end
      end
   end

   // Monitor: each new request is popped against the scoreboard, with idle-cycle and stability checks.
   logic        prev_req = 1'b0;
   int          idle = 0;
   logic [15:0] cap_addr = '0;
   logic [7:0]  cap_data = '0;
   bit          moved = 1'b0;
   exp_t        m;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
         idle     = 0;
      end else begin
         if (wr_req && !prev_req) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write at %0t", wr_addr, wr_data, $time);
            end else begin
               m = sbq.pop_front();
               check("wr_addr", wr_addr, m.addr);
               check("wr_data", wr_data, m.data);
               if (m.kind == K_EXACT) check("idle_exact", idle, m.idle);
               else if (m.kind == K_MIN) check("idle_min", idle >= m.idle, 1);
            end
            cap_addr = wr_addr;
            cap_data = wr_data;
            moved    = 1'b0;
         end else if (wr_req) begin
            if (wr_addr !== cap_addr || wr_data !== cap_data) moved = 1'b1;
         end else if (prev_req) begin
            check("req_stable", moved, 0);
            idle = 1;
         end else begin
            idle++;
         end
         prev_req = wr_req;
      end
   end

   // Reference model: derive the expected write stream and final status from the LUT and NACK plan.
   task automatic build_expect(input int size, output bit e_err, output int e_last);
      exp_t e;
      bit   first;
      bit   had_delay;
      int   pend;
      int   tries;
      first     = 1'b1;
      had_delay = 1'b0;
      pend      = 0;
      e_err     = 1'b0;
      e_last    = (size == 0) ? 0 : size - 1;
      for (int i = 0; i < size; i++) begin
         if (lut[i][23:8] == 16'hFFFF) begin
            had_delay = 1'b1;
            pend += int'(lut[i][7:0]) * UNIT;
         end else begin
            tries = (nack_plan[i] > MAXR) ? MAXR + 1 : nack_plan[i] + 1;
            for (int t = 0; t < tries; t++) begin
               e.addr = lut[i][23:8];
               e.data = lut[i][7:0];
               if (t > 0) begin
                  e.kind = K_EXACT; e.idle = GAP;
               end else if (first) begin
                  e.kind = K_SKIP;  e.idle = 0;
               end else if (had_delay) begin
                  e.kind = K_MIN;   e.idle = 2 + GAP + pend;
               end else begin
                  e.kind = K_EXACT; e.idle = 2 + GAP;
               end
               sbq.push_back(e);
               first = 1'b0;
            end
            had_delay = 1'b0;
            pend      = 0;
            if (nack_plan[i] > MAXR) begin
               e_err  = 1'b1;
               e_last = i;
               return;
            end
         end
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 256; i++) begin
         nack_plan[i] = 0;
         both_plan[i] = 1'b0;
         attempts[i]  = 0;
      end
   endtask

   task automatic fill_lut();
      for (int i = 0; i < 256; i++) lut[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
      lut[0]  = 24'h358B0A;
      lut[3]  = 24'h38DC00;
      lut[15] = 24'h311020;
   endtask

   task automatic reset_and_start(input int exp_cyc);
      int cyc;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_wr_req", wr_req, 0);
      check("rst_lut_index", lut_index, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", cfg_busy, 1);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);
      check("rst_err_index", err_index, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (wr_req || cfg_done) begin
            cyc = c;
            break;
         end
      end
      check("first_event_cycle", cyc, exp_cyc);
   endtask

   task automatic wait_end(input bit exp_err, input int exp_last);
      for (int c = 0; c < 6000 && !(cfg_done || cfg_err); c++) @(negedge clk);
      check("end_reached", cfg_done | cfg_err, 1);
      check("cfg_done", cfg_done, !exp_err);
      check("cfg_err", cfg_err, exp_err);
      check("cfg_busy_end", cfg_busy, 0);
      check("lut_index_end", lut_index, exp_last);
      if (exp_err) check("err_index", err_index, exp_last);
      repeat (60) @(negedge clk);
      check("sb_empty", sbq.size(), 0);
      check("no_req_after_end", wr_req, 0);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_busy", cfg_busy, 1);
      check("restart_done", cfg_done, 0);
      check("restart_err", cfg_err, 0);
      check("restart_err_index", err_index, 0);
      check("restart_lut_index", lut_index, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit e_err;
      int e_last;
      int sz;
      int di;
      bit found;

      // Clean 16-entry run, then restart from DONE.
      fill_lut();
      clear_plan();
      lut_size = 8'd16;
      build_expect(16, e_err, e_last);
      reset_and_start(12);
      wait_end(e_err, e_last);
      clear_plan();
      build_expect(16, e_err, e_last);
      do_restart();
      wait_end(e_err, e_last);

      // Entry 3 NACKed twice then ACKed.
      clear_plan();
      nack_plan[3] = 2;
      build_expect(16, e_err, e_last);
      reset_and_start(12);
      wait_end(e_err, e_last);

      // Entry 5 exhausts its retries; restart then runs clean.
      clear_plan();
      nack_plan[5] = 4;
      build_expect(16, e_err, e_last);
      reset_and_start(12);
      wait_end(e_err, e_last);
      clear_plan();
      build_expect(16, e_err, e_last);
      do_restart();
      wait_end(e_err, e_last);

      // Delay entry, done+nack together, stray pulses, restart mid-run ignored.
      clear_plan();
      lut[2] = 24'hFFFF02;
      nack_plan[4] = 1;
      both_plan[4] = 1'b1;
      stray_en = 1'b1;
      build_expect(16, e_err, e_last);
      reset_and_start(12);
      repeat (100) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_ignored_busy", cfg_busy, 1);
      wait_end(e_err, e_last);

      // Randomised LUT contents, sizes, NACK plans and a delay entry.
      for (int r = 0; r < 4; r++) begin
         fill_lut();
         clear_plan();
         sz = int'($urandom_range(1, 16));
         lut_size = 8'(sz);
         for (int i = 0; i < sz; i++) begin
            if ($urandom_range(0, 3) == 0) nack_plan[i] = int'($urandom_range(1, MAXR + 1));
            both_plan[i] = ($urandom_range(0, 1) == 1);
         end
         if (sz > 2) begin
            di = int'($urandom_range(1, sz - 1));
            lut[di] = {16'hFFFF, 8'($urandom_range(0, 2))};
         end
         build_expect(sz, e_err, e_last);
         reset_and_start(12);
         wait_end(e_err, e_last);
      end
      stray_en = 1'b0;

      // Reset while entry 7 is in flight.
      fill_lut();
      clear_plan();
      lut_size = 8'd16;
      build_expect(16, e_err, e_last);
      reset_and_start(12);
      found = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (wr_req && lut_index == 8'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_issue7", found, 1);
      rst_n = 1'b0;
      sbq.delete();
      @(posedge clk);
      #1;
      check("midrst_req_drop", wr_req, 0);
      check("midrst_lut_index", lut_index, 0);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_busy", cfg_busy, 1);
      clear_plan();
      build_expect(16, e_err, e_last);
      reset_and_start(12);
      wait_end(e_err, e_last);

      // Empty LUT finishes straight after power-up; single-entry LUT.
      clear_plan();
      lut_size = 8'd0;
      build_expect(0, e_err, e_last);
      reset_and_start(11);
      wait_end(e_err, e_last);
      lut_size = 8'd1;
      build_expect(1, e_err, e_last);
      reset_and_start(12);
      wait_end(e_err, e_last);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmos_i2c_cfg_sequencer.md
Name: cmos_i2c_cfg_sequencer

Overview:
Walks a sensor register LUT (16-bit register address + 8-bit data per entry) after power-up and issues each entry as one write transaction to the I2C write master. It sits between the per-sensor config LUT and the I2C master in the cmos_i2c block. It adds a power-up wait, a gap between writes, timed-delay pseudo-entries, NACK retry, and done/error status for the capture pipeline.

Parameters:
PWRUP_CYC, 20'd500000, cycles to wait after reset or restart before the first LUT fetch
GAP_CYC, 16'd1000, idle cycles between consecutive write transactions (also applies before a retry)
DELAY_UNIT_CYC, 16'd50000, cycles per unit of a delay pseudo-entry
DELAY_ADDR, 16'hFFFF, register address that marks a delay pseudo-entry instead of a write
MAX_RETRY, 4'd3, extra attempts allowed per entry after a NACK

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
restart  in  1  one-cycle pulse; re-runs the whole sequence; honoured only in DONE or ERROR
LUT_INDEX  out  8  entry index presented to the config LUT
LUT_DATA  in  24  {reg_addr[15:0], reg_data[7:0]}; LUT is combinational
LUT_SIZE  in  8  number of valid entries
wr_req  out  1  write request to the I2C master; level signal
wr_addr  out  16  register address; stable while wr_req=1
wr_data  out  8  register data; stable while wr_req=1
wr_done  in  1  one-cycle pulse: transaction ACKed
wr_nack  in  1  one-cycle pulse: transaction failed (NACK)
cfg_busy  out  1  sequence in progress
cfg_done  out  1  all entries written; held until restart or reset
cfg_err  out  1  retry limit exhausted; held until restart or reset
err_index  out  8  LUT_INDEX of the failing entry; valid while cfg_err=1

Behaviour:
- Reset (rst_n=0 sampled at posedge clk): state PWRUP, counters cleared, LUT_INDEX=0, wr_req=0, wr_addr=0, wr_data=0, cfg_busy=1, cfg_done=0, cfg_err=0, err_index=0.
- PWRUP: count PWRUP_CYC cycles. Then go to FETCH if LUT_SIZE≠0, otherwise go to DONE.
- FETCH (1 cycle): register LUT_DATA for the current LUT_INDEX. If addr==DELAY_ADDR, go to DELAY with count=data*DELAY_UNIT_CYC; the 24-bit product is computed at full width. A data value of 0 means zero wait. Otherwise load wr_addr/wr_data and go to ISSUE.
- ISSUE: wr_req=1 from the cycle after FETCH. It stays high until wr_done or wr_nack is sampled, and drops the next cycle. wr_addr/wr_data must not change while wr_req=1.
- Response handling:
  - wr_done: clear the retry count, go to NEXT.
  - wr_nack: if retry count < MAX_RETRY, increment it and go to GAP, then re-ISSUE the same entry. Otherwise go to ERROR and set err_index=LUT_INDEX.
  - wr_done and wr_nack in the same cycle count as a NACK.
  - Pulses arriving while wr_req=0 are ignored.
- NEXT: if LUT_INDEX==LUT_SIZE-1, go to DONE; otherwise increment LUT_INDEX and go to GAP, then FETCH. LUT_INDEX never wraps past LUT_SIZE-1. A delay entry also passes through NEXT, with no GAP after DELAY.
- GAP: GAP_CYC idle cycles with wr_req=0. GAP_CYC=0 means a single-cycle pass-through.
- DONE: cfg_done=1, cfg_busy=0, LUT_INDEX holds the last value.
- ERROR: cfg_err=1, cfg_busy=0, wr_req=0, no further writes.
- restart in DONE or ERROR: clear done/err/err_index/retry count, set LUT_INDEX=0, cfg_busy=1, go to PWRUP. restart is ignored in every other state.
- Reset mid-transaction: wr_req drops on the next posedge. The I2C master is reset by the same rst_n.
- Minimum latency, entry to entry: FETCH(1) + ISSUE (master time) + NEXT(1) + GAP_CYC.

Decomposition:
- Shared package cmos_i2c_pkg: state encoding (PWRUP, FETCH, ISSUE, DELAY, NEXT, GAP, DONE, ERROR), DELAY_ADDR default, LUT entry field widths (ADDR_W=16, DATA_W=8, IDX_W=8).
- One sub-module: cfg_wait_counter. It is a loadable down-counter with a zero flag, shared by PWRUP, GAP and DELAY (24-bit width). Everything else stays flat.

Test Plan:
- Power-up, 16-entry LUT (entry0={16'h358B,8'h0A} … entry15={16'h3110,8'h20}), PWRUP_CYC=10, GAP_CYC=4, master ACKs 8 cycles after req → first wr_req at cycle 12 with wr_addr=16'h358B, wr_data=8'h0A. Exactly 16 writes in index order, then cfg_done=1, cfg_busy=0, LUT_INDEX=15.
- NACK on entry 3 ({16'h38dc,8'h00}) twice, then ACK, MAX_RETRY=3 → entry 3 issued 3 times, each reissue preceded by 4 idle cycles. The sequence completes and cfg_err stays 0.
- Entry 5 NACKed 4 times → cfg_err=1, err_index=5, no wr_req afterwards, entries 6–15 never issued. A restart pulse then runs all entries from index 0 after PWRUP.
- Delay entry {16'hFFFF,8'h02} at index 2, DELAY_UNIT_CYC=100 → no wr_req for that index. At least 200 idle cycles pass between the end of entry 1 and the first req of entry 3.
- wr_done and wr_nack asserted together, and a stray wr_done while wr_req=0 → the first is treated as a NACK (retry), the second is ignored. wr_addr/wr_data are constant during every req (assertion).
- rst_n=0 in mid-ISSUE at entry 7 → wr_req=0 the next cycle, outputs return to reset values, and the sequence restarts from index 0 after PWRUP. LUT_SIZE=0 → cfg_done right after PWRUP with zero writes.
